// File: rtl/btn_event.sv
// ---------------------------------------------------------------------------
// btn_event
//
// Turns the debounced, clk-synchronous button level into single-cycle
// events (press, release, long-press, auto-repeat). It also keeps a sticky,
// ack-cleared copy of the most recent unread event for the CPU MMIO poller.
// There is one instance per physical button.
//
// Parameters
//   LONG_CYCLES   : held cycles after press before long_pulse (>= 2)
//   REPEAT_CYCLES : cycles between repeat_pulse in the long-held state,
//                   0 disables auto-repeat
//   CNT_W         : hold counter width, 2**CNT_W > max(LONG, REPEAT)
//
// Ports
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   btn_level     : debounced button level (active high, already in clk)
//   press_pulse   : one-cycle pulse on press
//   release_pulse : one-cycle pulse on release
//   long_pulse    : one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  : one-cycle pulse every REPEAT_CYCLES after long
//   held          : high while in PRESSED or LONG
//   evt_valid     : sticky "unread event" flag
//   evt_code      : latched event, 00 press, 01 release, 10 long, 11 repeat
//   evt_overrun   : an event was dropped while evt_valid was set
//   evt_ack       : consumer read strobe, single cycle
// ---------------------------------------------------------------------------
module btn_event #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  input  logic       evt_ack,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_overrun
);

  // State encoding. WAIT_REL is the reset state, so a button that is
  // already down when reset is released never reports a press.
  localparam logic [1:0] ST_WAIT_REL = 2'b00;
  localparam logic [1:0] ST_IDLE     = 2'b01;
  localparam logic [1:0] ST_PRESSED  = 2'b10;
  localparam logic [1:0] ST_LONG     = 2'b11;

  // Event codes as seen by the MMIO poller.
  localparam logic [1:0] CODE_PRESS   = 2'b00;
  localparam logic [1:0] CODE_RELEASE = 2'b01;
  localparam logic [1:0] CODE_LONG    = 2'b10;
  localparam logic [1:0] CODE_REPEAT  = 2'b11;

  // Terminal counts. The counter restarts from zero on entry to PRESSED
  // and LONG, so the last value before a threshold fires is N-1.
  localparam bit             REPEAT_EN   = (REPEAT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST =
    REPEAT_EN ? CNT_W'(REPEAT_CYCLES - 32'd1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Maps the one-hot event flags of this edge onto the 2-bit code. At most
  // one flag can be set per edge, the priority order only matters for
  // synthesis of the mux.
  function automatic logic [1:0] encode_evt(
    input logic ev_press,
    input logic ev_release,
    input logic ev_long
  );
    logic [1:0] code;
    if (ev_press) begin
      code = CODE_PRESS;
    end else if (ev_release) begin
      code = CODE_RELEASE;
    end else if (ev_long) begin
      code = CODE_LONG;
    end else begin
      code = CODE_REPEAT;
    end
    return code;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic             ev_press_s;
  logic             ev_release_s;
  logic             ev_long_s;
  logic             ev_repeat_s;
  logic             ev_any_s;
  logic [1:0]       ev_code_s;

  logic             press_r;
  logic             release_r;
  logic             long_r;
  logic             repeat_r;
  logic             held_r;

  logic             evt_valid_r;
  logic [1:0]       evt_code_r;
  logic             evt_overrun_r;
  logic             evt_valid_nxt_s;
  logic [1:0]       evt_code_nxt_s;
  logic             evt_overrun_nxt_s;

  // Next-state, hold counter and event decode for the button FSM.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    ev_press_s   = 1'b0;
    ev_release_s = 1'b0;
    ev_long_s    = 1'b0;
    ev_repeat_s  = 1'b0;

    case (state_r)
      ST_WAIT_REL: begin
        if (!btn_level) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_REL;
        end
      end

      ST_IDLE: begin
        if (btn_level) begin
          state_nxt_s = ST_PRESSED;
          cnt_nxt_s   = CNT_ZERO;
          ev_press_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      // Release is tested first so it wins over a threshold on the same edge.
      ST_PRESSED: begin
        if (!btn_level) begin
          state_nxt_s  = ST_IDLE;
          cnt_nxt_s    = CNT_ZERO;
          ev_release_s = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          state_nxt_s = ST_LONG;
          cnt_nxt_s   = CNT_ZERO;
          ev_long_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end

      // With repeat disabled the counter parks at all-ones instead of
      // wrapping, so an arbitrarily long hold stays quiet.
      ST_LONG: begin
        if (!btn_level) begin
          state_nxt_s  = ST_IDLE;
          cnt_nxt_s    = CNT_ZERO;
          ev_release_s = 1'b1;
        end else if (REPEAT_EN && (cnt_r == REPEAT_LAST)) begin
          cnt_nxt_s   = CNT_ZERO;
          ev_repeat_s = 1'b1;
        end else if (REPEAT_EN || (cnt_r != CNT_MAX)) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      default: begin
        state_nxt_s = ST_WAIT_REL;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Collapse this edge's event flags into "any event" plus its code.
  always_comb begin
    ev_any_s  = ev_press_s | ev_release_s | ev_long_s | ev_repeat_s;
    ev_code_s = encode_evt(ev_press_s, ev_release_s, ev_long_s);
  end

  // Sticky event register: the oldest unread event is kept, a later one
  // only raises overrun. An ack in the same cycle as a new event frees the
  // slot, so the new event is latched cleanly.
  always_comb begin
    evt_valid_nxt_s   = evt_valid_r;
    evt_code_nxt_s    = evt_code_r;
    evt_overrun_nxt_s = evt_overrun_r;
    if (ev_any_s && (!evt_valid_r || evt_ack)) begin
      evt_valid_nxt_s   = 1'b1;
      evt_code_nxt_s    = ev_code_s;
      evt_overrun_nxt_s = 1'b0;
    end else if (ev_any_s) begin
      evt_overrun_nxt_s = 1'b1;
    end else if (evt_ack) begin
      evt_valid_nxt_s   = 1'b0;
      evt_overrun_nxt_s = 1'b0;
    end else begin
      evt_valid_nxt_s   = evt_valid_r;
      evt_code_nxt_s    = evt_code_r;
      evt_overrun_nxt_s = evt_overrun_r;
    end
  end

  // FSM state and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_WAIT_REL;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered pulses and held flag, all reflecting the edge just taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      press_r   <= ev_press_s;
      release_r <= ev_release_s;
      long_r    <= ev_long_s;
      repeat_r  <= ev_repeat_s;
      held_r    <= (state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_LONG);
    end
  end

  // Event register storage, updated in the same cycle as the matching pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_r   <= 1'b0;
      evt_code_r    <= CODE_PRESS;
      evt_overrun_r <= 1'b0;
    end else begin
      evt_valid_r   <= evt_valid_nxt_s;
      evt_code_r    <= evt_code_nxt_s;
      evt_overrun_r <= evt_overrun_nxt_s;
    end
  end

  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign long_pulse    = long_r;
  assign repeat_pulse  = repeat_r;
  assign held          = held_r;
  assign evt_valid     = evt_valid_r;
  assign evt_code      = evt_code_r;
  assign evt_overrun   = evt_overrun_r;

endmodule

// File: tb/tb_btn_event.sv
module tb_btn_event;

  // Expected pulse vector layout: {press, release, long, repeat, held}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] H    = 5'b00001;
  localparam logic [4:0] P    = 5'b10000;
  localparam logic [4:0] R    = 5'b01000;
  localparam logic [4:0] L    = 5'b00100;
  localparam logic [4:0] RP   = 5'b00010;

  typedef struct {
    logic [4:0] pulses;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       ack;
  logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic       evt_valid, evt_overrun;
  logic [1:0] evt_code;

  logic       btn0;
  logic       ack0;
  logic       press0, release0, long0, repeat0, held0;
  logic       evt_valid0, evt_overrun0;
  logic [1:0] evt_code0;

  exp_t       sb_q[$];
  int         n_chk;
  int         n_fail;
  int         long_cnt;
  int         rep_cnt;
  int         long_at;

  btn_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn),
    .evt_ack      (ack),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_overrun  (evt_overrun)
  );

  btn_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn0),
    .evt_ack      (ack0),
    .press_pulse  (press0),
    .release_pulse(release0),
    .long_pulse   (long0),
    .repeat_pulse (repeat0),
    .held         (held0),
    .evt_valid    (evt_valid0),
    .evt_code     (evt_code0),
    .evt_overrun  (evt_overrun0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic immediate-assertion comparison.
  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue the expected pulse vector, then compare after the edge.
  task automatic cyc(input logic b, input logic a, input logic [4:0] exp, input string tag);
    exp_t e;
    exp_t got;
    btn = b;
    ack = a;
    e.pulses = exp;
    e.tag    = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check(got.tag, {4'b0000, press_pulse, release_pulse, long_pulse, repeat_pulse, held},
          {4'b0000, got.pulses});
  endtask

  task automatic chk_evt(input logic v, input logic [1:0] c, input logic o, input string tag);
    check(tag, {6'b000000, evt_valid, evt_code, evt_overrun}, {6'b000000, v, c, o});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    btn    = 1'b1;
    ack    = 1'b0;
    btn0   = 1'b0;
    ack0   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {press_pulse, release_pulse, long_pulse, repeat_pulse, held, evt_valid, evt_code, evt_overrun},
          9'b000000000);
    check("reset_outputs_dut0",
          {press0, release0, long0, repeat0, held0, evt_valid0, evt_code0, evt_overrun0},
          9'b000000000);
    rst_n = 1'b1;

    // 1: button down across reset is ignored until released.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, NONE, "wait_rel_hold");
    chk_evt(1'b0, 2'b00, 1'b0, "wait_rel_no_event");
    cyc(1'b0, 1'b0, NONE, "wait_rel_drop");
    cyc(1'b1, 1'b0, P | H, "first_press");
    chk_evt(1'b1, 2'b00, 1'b0, "first_press_evt");

    // 2: short press (3 high edges), release dropped as overrun.
    cyc(1'b1, 1'b0, H, "short_hold");
    cyc(1'b1, 1'b0, H, "short_hold");
    cyc(1'b0, 1'b0, R, "short_release");
    chk_evt(1'b1, 2'b00, 1'b1, "short_overrun");
    cyc(1'b0, 1'b0, NONE, "short_idle");
    chk_evt(1'b1, 2'b00, 1'b1, "short_overrun_sticky");
    cyc(1'b0, 1'b1, NONE, "short_ack");
    chk_evt(1'b0, 2'b00, 1'b0, "short_ack_clear");

    // Glitch: one high cycle gives press then release.
    cyc(1'b1, 1'b0, P | H, "glitch_press");
    cyc(1'b0, 1'b0, R, "glitch_release");
    chk_evt(1'b1, 2'b00, 1'b1, "glitch_evt");
    cyc(1'b0, 1'b1, NONE, "glitch_ack");
    chk_evt(1'b0, 2'b00, 1'b0, "glitch_ack_clear");

    // 3: long hold with ack held high, so each event is latched with its code.
    cyc(1'b1, 1'b1, P | H, "long_press");
    chk_evt(1'b1, 2'b00, 1'b0, "long_press_evt");
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, H, "long_count");
    cyc(1'b1, 1'b1, L | H, "long_pulse");
    chk_evt(1'b1, 2'b10, 1'b0, "long_evt");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, H, "rep_count1");
    cyc(1'b1, 1'b1, RP | H, "repeat1");
    chk_evt(1'b1, 2'b11, 1'b0, "repeat1_evt");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, H, "rep_count2");
    cyc(1'b1, 1'b1, RP | H, "repeat2");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, H, "rep_count3");
    cyc(1'b0, 1'b1, R, "release_beats_repeat");
    chk_evt(1'b1, 2'b01, 1'b0, "long_release_evt");
    cyc(1'b0, 1'b1, NONE, "long_ack");
    chk_evt(1'b0, 2'b01, 1'b0, "long_ack_clear");

    // 4: ack handshake.
    cyc(1'b1, 1'b0, P | H, "ack_press");
    chk_evt(1'b1, 2'b00, 1'b0, "ack_press_evt");
    cyc(1'b1, 1'b1, H, "ack_read");
    chk_evt(1'b0, 2'b00, 1'b0, "ack_read_clear");
    cyc(1'b1, 1'b0, H, "ack_hold");
    cyc(1'b0, 1'b1, R, "ack_release");
    chk_evt(1'b1, 2'b01, 1'b0, "ack_release_evt");
    cyc(1'b1, 1'b1, P | H, "ack_replace_press");
    chk_evt(1'b1, 2'b00, 1'b0, "ack_replace_evt");
    cyc(1'b1, 1'b0, H, "ack_hold2");
    cyc(1'b0, 1'b0, R, "drop_release");
    chk_evt(1'b1, 2'b00, 1'b1, "oldest_wins");
    cyc(1'b1, 1'b0, P | H, "drop_press");
    chk_evt(1'b1, 2'b00, 1'b1, "oldest_wins2");
    cyc(1'b0, 1'b1, R, "release_with_ack");
    chk_evt(1'b1, 2'b01, 1'b0, "release_with_ack_evt");
    cyc(1'b0, 1'b1, NONE, "ack_clear2");
    chk_evt(1'b0, 2'b01, 1'b0, "ack_clear2_evt");
    cyc(1'b0, 1'b1, NONE, "ack_when_empty");
    chk_evt(1'b0, 2'b01, 1'b0, "ack_when_empty_evt");

    // 5: repeat disabled, 40-cycle hold on the second instance.
    btn = 1'b0;
    ack = 1'b0;
    long_cnt = 0;
    rep_cnt  = 0;
    long_at  = -1;
    for (int i = 0; i < 40; i++) begin
      btn0 = 1'b1;
      @(posedge clk);
      #1;
      if (long0) begin
        long_cnt++;
        long_at = i;
      end
      if (repeat0) rep_cnt++;
      check("norep_held", {8'h00, held0}, 9'b000000001);
    end
    check("norep_long_count", 9'(long_cnt), 9'd1);
    check("norep_long_at", 9'(long_at), 9'd8);
    check("norep_repeat_count", 9'(rep_cnt), 9'd0);
    btn0 = 1'b0;
    @(posedge clk);
    #1;
    check("norep_release", {7'b0000000, release0, held0}, 9'b000000010);

    // 6: asynchronous reset in the middle of LONG.
    cyc(1'b1, 1'b0, P | H, "rst_press");
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, H, "rst_count");
    cyc(1'b1, 1'b0, L | H, "rst_long");
    cyc(1'b1, 1'b0, H, "rst_in_long");
    cyc(1'b1, 1'b0, H, "rst_in_long");
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {press_pulse, release_pulse, long_pulse, repeat_pulse, held, evt_valid, evt_code, evt_overrun},
          9'b000000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, NONE, "post_rst_wait_rel");
    chk_evt(1'b0, 2'b00, 1'b0, "post_rst_evt");
    cyc(1'b0, 1'b0, NONE, "post_rst_drop");
    cyc(1'b1, 1'b0, P | H, "post_rst_press");
    cyc(1'b0, 1'b0, R, "post_rst_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
